// File: rtl/pe_pkg.sv
// Shared types and constants for the PE psum collector slice.
package pe_pkg;
  localparam int PE_DATA_W   = 16;
  // PE_EN is registered, so one slot stays free for a sample already in flight
  localparam int PE_EN_SLACK = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } coll_state_e;
endpackage

// File: rtl/pe_psum_collector_if.sv
// PE-side and memory-side signals of the psum collector, bundled in one interface.
interface pe_psum_collector_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
);
  logic                  start;
  logic [CNT_WIDTH-1:0]  row_len;
  logic [DATA_WIDTH-1:0] psum_data_P2M;
  logic                  PE_VALID;
  logic                  PE_EN;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  busy;
  logic                  done;
  logic                  overflow;

  modport master (
    output start, row_len, psum_data_P2M, PE_VALID, out_ready,
    input  PE_EN, out_data, out_valid, out_last, busy, done, overflow
  );

  modport slave (
    input  start, row_len, psum_data_P2M, PE_VALID, out_ready,
    output PE_EN, out_data, out_valid, out_last, busy, done, overflow
  );
endinterface

// File: rtl/pe_sync_fifo.sv
// First-word-fall-through synchronous FIFO; push while full is accepted only with a same-cycle pop.
module pe_sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr, rptr;
  logic                  do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // storage needs no reset: dout is masked while empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

// File: rtl/pe_psum_collector.sv
// Buffers one row of PE partial sums, throttles the PE via PE_EN, streams the row downstream.
module pe_psum_collector
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = PE_DATA_W,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 8,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  pe_psum_collector_if.slave bus
);
  coll_state_e           state, state_n;
  logic [CNT_WIDTH-1:0]  row_len_q, push_cnt, pop_cnt;
  logic                  pe_en_q, overflow_q;
  logic                  push, pop, drop, last_beat, in_row;
  logic                  full, empty;
  logic [CW-1:0]         count, count_nxt;
  logic [DATA_WIDTH-1:0] head;

  pe_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (bus.psum_data_P2M),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign in_row    = (state == COLLECT) && bus.PE_VALID && (push_cnt < row_len_q);
  assign pop       = !empty && bus.out_ready;
  assign push      = in_row && (!full || pop);
  assign drop      = in_row && full && !pop;
  assign last_beat = (pop_cnt == row_len_q - CNT_WIDTH'(1));
  assign count_nxt = count + CW'(push) - CW'(pop);

  assign bus.out_valid = !empty;
  assign bus.out_data  = head;
  assign bus.out_last  = !empty && last_beat;
  assign bus.PE_EN     = pe_en_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.overflow  = overflow_q;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.start) state_n = (bus.row_len != '0) ? COLLECT : DONE;
      COLLECT: if (push && (push_cnt == row_len_q - CNT_WIDTH'(1))) state_n = DRAIN;
      DRAIN:   if (pop && last_beat) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      row_len_q  <= '0;
      push_cnt   <= '0;
      pop_cnt    <= '0;
      pe_en_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.start) begin
        row_len_q  <= bus.row_len;
        push_cnt   <= '0;
        pop_cnt    <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (push) push_cnt <= push_cnt + CNT_WIDTH'(1);
        if (pop)  pop_cnt  <= pop_cnt + CNT_WIDTH'(1);
        if (drop) overflow_q <= 1'b1;
      end
      // computed from next-cycle state/occupancy so the registered flag tracks the current ones
      pe_en_q <= (state_n == COLLECT) && (count_nxt <= CW'(FIFO_DEPTH - 1 - PE_EN_SLACK));
    end
  end
endmodule

// File: tb/tb_pe_psum_collector.sv
// Directed self-checking bench for pe_psum_collector.
module tb_pe_psum_collector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  pe_psum_collector_if #(.DATA_WIDTH(16), .CNT_WIDTH(8)) bus ();

  pe_psum_collector #(.DATA_WIDTH(16), .FIFO_DEPTH(8), .CNT_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_row(input logic [7:0] len);
    bus.start   = 1'b1;
    bus.row_len = len;
    tick();
    bus.start   = 1'b0;
  endtask

  initial begin
    int sent, got, npop, seen_valid;
    logic [15:0] rx [$];
    logic [15:0] lastd;
    logic        lastf;

    bus.start = 0; bus.row_len = 0; bus.psum_data_P2M = 0;
    bus.PE_VALID = 0; bus.out_ready = 0;
    tick(); tick();
    chk("rst_pe_en", bus.PE_EN, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ovf", bus.overflow, 0);
    rst = 0;
    tick();

    // 1: basic row of three
    start_row(8'd3);
    chk("t1_pe_en", bus.PE_EN, 1);
    chk("t1_busy", bus.busy, 1);
    bus.out_ready = 1;
    bus.PE_VALID = 1; bus.psum_data_P2M = 16'h0001; tick();
    chk("t1_d1", bus.out_data, 16'h0001);
    chk("t1_v1", bus.out_valid, 1);
    chk("t1_l1", bus.out_last, 0);
    bus.psum_data_P2M = 16'h0002; tick();
    chk("t1_d2", bus.out_data, 16'h0002);
    chk("t1_l2", bus.out_last, 0);
    bus.psum_data_P2M = 16'h0003; tick();
    bus.PE_VALID = 0;
    chk("t1_d3", bus.out_data, 16'h0003);
    chk("t1_l3", bus.out_last, 1);
    tick();
    chk("t1_done", bus.done, 1);
    chk("t1_v_after", bus.out_valid, 0);
    tick();
    chk("t1_done_off", bus.done, 0);
    chk("t1_busy_off", bus.busy, 0);

    // 2: backpressure, PE obeys PE_EN
    bus.out_ready = 0;
    start_row(8'd10);
    sent = 0;
    for (int c = 0; c < 20 && bus.PE_EN; c++) begin
      bus.PE_VALID = 1; bus.psum_data_P2M = 16'h0100 + 16'(sent); sent++;
      tick();
    end
    bus.PE_VALID = 0;
    chk("t2_sent_at_stop", sent, 7);
    chk("t2_pe_en_low", bus.PE_EN, 0);
    tick();
    chk("t2_pe_en_hold", bus.PE_EN, 0);
    bus.out_ready = 1;
    for (int c = 0; c < 60 && !bus.done; c++) begin
      if (bus.out_valid) rx.push_back(bus.out_data);
      bus.PE_VALID = bus.PE_EN && (sent < 10);
      bus.psum_data_P2M = 16'h0100 + 16'(sent);
      if (bus.PE_VALID) sent++;
      tick();
    end
    bus.PE_VALID = 0;
    chk("t2_done", bus.done, 1);
    chk("t2_nrx", rx.size(), 10);
    got = 0;
    foreach (rx[i]) if (rx[i] !== 16'h0100 + 16'(i)) got++;
    chk("t2_order_errs", got, 0);
    chk("t2_ovf", bus.overflow, 0);
    tick();

    // 4: full FIFO with simultaneous push and pop
    bus.out_ready = 0;
    start_row(8'd12);
    for (int i = 0; i < 8; i++) begin
      bus.PE_VALID = 1; bus.psum_data_P2M = 16'h0300 + 16'(i); tick();
    end
    chk("t4_full_cnt", dut.u_fifo.count, 8);
    chk("t4_pe_en", bus.PE_EN, 0);
    chk("t4_head", bus.out_data, 16'h0300);
    bus.out_ready = 1; bus.psum_data_P2M = 16'h03AA;
    npop = 1; lastd = bus.out_data; lastf = bus.out_last;
    tick();
    chk("t4_cnt_same", dut.u_fifo.count, 8);
    chk("t4_ovf", bus.overflow, 0);
    chk("t4_push_cnt", dut.push_cnt, 9);
    chk("t4_head2", bus.out_data, 16'h0301);
    for (int c = 0; c < 40 && !bus.done; c++) begin
      bus.PE_VALID = (c < 3);
      bus.psum_data_P2M = 16'h03B0 + 16'(c);
      if (bus.out_valid) begin npop++; lastd = bus.out_data; lastf = bus.out_last; end
      tick();
    end
    bus.PE_VALID = 0;
    chk("t4_done", bus.done, 1);
    chk("t4_npop", npop, 12);
    chk("t4_lastd", lastd, 16'h03B2);
    chk("t4_lastf", lastf, 1);
    tick();

    // 3: overflow, PE ignores PE_EN
    bus.out_ready = 0;
    start_row(8'd12);
    for (int i = 0; i < 9; i++) begin
      bus.PE_VALID = 1; bus.psum_data_P2M = 16'h0200 + 16'(i); tick();
    end
    bus.PE_VALID = 0;
    chk("t3_ovf", bus.overflow, 1);
    chk("t3_push_cnt", dut.push_cnt, 8);
    chk("t3_state", 32'(dut.state), 1);
    chk("t3_head", bus.out_data, 16'h0200);
    tick();
    chk("t3_ovf_sticky", bus.overflow, 1);

    // reset mid-row clears everything immediately
    rst = 1; #1;
    chk("t3_rst_ovf", bus.overflow, 0);
    chk("t3_rst_valid", bus.out_valid, 0);
    tick(); rst = 0; tick();

    // 5: zero-length row
    seen_valid = 0;
    start_row(8'd0);
    seen_valid += bus.out_valid;
    chk("t5_done", bus.done, 1);
    tick();
    seen_valid += bus.out_valid;
    chk("t5_done_off", bus.done, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_no_valid", seen_valid, 0);

    // 6: reset after two pushes, then a fresh row
    bus.out_ready = 0;
    start_row(8'd5);
    bus.PE_VALID = 1; bus.psum_data_P2M = 16'h0050; tick();
    bus.psum_data_P2M = 16'h0051; tick();
    bus.PE_VALID = 0;
    rst = 1; #1;
    chk("t6_rst_valid", bus.out_valid, 0);
    chk("t6_rst_data", bus.out_data, 0);
    chk("t6_rst_pe_en", bus.PE_EN, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_cnt", dut.u_fifo.count, 0);
    tick(); rst = 0;
    chk("t6_no_done", bus.done, 0);
    tick();
    start_row(8'd2);
    bus.out_ready = 1;
    bus.PE_VALID = 1; bus.psum_data_P2M = 16'h000A; tick();
    chk("t6_d1", bus.out_data, 16'h000A);
    chk("t6_l1", bus.out_last, 0);
    bus.psum_data_P2M = 16'h000B; tick();
    bus.PE_VALID = 0;
    chk("t6_d2", bus.out_data, 16'h000B);
    chk("t6_l2", bus.out_last, 1);
    tick();
    chk("t6_done", bus.done, 1);
    tick();
    chk("t6_idle", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pe_psum_collector.md
Name: pe_psum_collector

Overview:
Sink-side counterpart of the PE stimulus path. It receives partial sums leaving a processing element (psum_data_P2M qualified by PE_VALID) and buffers them in a small FIFO. It throttles the PE through PE_EN and streams one row of results to the memory side over a valid/ready handshake. It sits between the PE output and the output-buffer writer.

Parameters:
DATA_WIDTH, 16, width of one partial sum
FIFO_DEPTH, 8, buffer entries (power of two, >= 4)
CNT_WIDTH, 8, width of row-length and beat counters

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle pulse, begins a row; sampled only in IDLE
row_len  input  CNT_WIDTH  number of psums in the row; latched on start
psum_data_P2M  input  DATA_WIDTH  partial sum from PE
PE_VALID  input  1  psum_data_P2M valid this cycle
PE_EN  output  1  enable/throttle to PE
out_data  output  DATA_WIDTH  FIFO head
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts
out_last  output  1  marks final beat of row (qualified by out_valid)
busy  output  1  state != IDLE
done  output  1  one-cycle pulse after last beat is handshaked
overflow  output  1  sticky; PE_VALID arrived while FIFO full and no pop

Behaviour:
- Reset (async, rst=1): state IDLE, FIFO empty, counters 0, row_len_q 0. PE_EN=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0, overflow=0. Reset mid-row discards all buffered data; no done pulse.
- FSM states: IDLE, COLLECT, DRAIN, DONE.
- IDLE:
  - start=1 and row_len!=0 -> COLLECT; latch row_len_q; clear push_cnt, pop_cnt, overflow.
  - start=1 and row_len==0 -> DONE directly; no beats are produced.
  - start outside IDLE is ignored.
- COLLECT:
  - push = PE_VALID && push_cnt<row_len_q && (!full || pop).
  - push_cnt increments on push.
  - When push brings push_cnt to row_len_q -> DRAIN.
- DRAIN: no pushes. Advance to DONE on the cycle the beat with pop_cnt==row_len_q-1 is handshaked.
- DONE: done=1 for exactly one cycle, then -> IDLE.
- Push handling: PE_VALID in IDLE, DRAIN or DONE is ignored and does not set overflow. PE_VALID in COLLECT while full and no same-cycle pop: sample dropped, push_cnt unchanged, overflow set (sticky until next start or rst).
- PE_EN = (state==COLLECT) && (count <= FIFO_DEPTH-2). PE_EN is registered, so the threshold leaves one slot of slack for a sample already in flight.
- Output is first-word-fall-through:
  - out_valid = !empty; out_data = FIFO head.
  - A psum pushed in cycle N is visible on out_data in cycle N+1.
  - out_data and out_last stay stable while out_valid && !out_ready.
  - out_data reads 0 when empty.
- pop = out_valid && out_ready. pop_cnt increments on pop.
- out_last = out_valid && (pop_cnt == row_len_q-1).
- Simultaneous push and pop: allowed at any occupancy, including full and empty; count unchanged. At empty, the pop is invalid, so only the push occurs.
- Pointers wrap modulo FIFO_DEPTH. Count range is 0..FIFO_DEPTH; full = (count==FIFO_DEPTH).
- Counters never exceed row_len_q. There is no arithmetic on data; values pass through bit-exact.

Decomposition:
- Package pe_pkg: collector state enum (IDLE, COLLECT, DRAIN, DONE), default DATA_WIDTH constant, and the PE_EN threshold slack constant (1).
- Sub-module pe_sync_fifo (DATA_WIDTH, DEPTH): FWFT synchronous FIFO with push, pop, full, empty and count outputs, and async active-high reset.
- pe_psum_collector holds the FSM, counters, PE_EN register and overflow flag.

Test Plan:
1. Basic row: start, row_len=3; PE_VALID with psums 0x0001, 0x0002, 0x0003 on consecutive cycles; out_ready=1 -> outputs 1, 2, 3 each one cycle after push; out_last on 0x0003; done one cycle after that handshake; busy low afterwards.
2. Backpressure: row_len=10, out_ready=0 -> PE_EN drops once count reaches 7. Raise out_ready -> all 10 values emerge in order, overflow=0.
3. Overflow: row_len=12, out_ready=0, PE_VALID forced high ignoring PE_EN -> first 8 samples stored, 9th dropped, overflow=1 and stays high. push_cnt=8, FSM remains in COLLECT.
4. Full with simultaneous push/pop: FIFO full, out_ready=1, PE_VALID=1 in the same cycle -> push accepted, count stays 8, no overflow.
5. Zero length: start with row_len=0 -> DONE next cycle, done pulse, no out_valid ever asserted.
6. Reset mid-row: row_len=5, after 2 pushes assert rst for 1 cycle -> all outputs at reset values immediately, FIFO empty. A later start with row_len=2 behaves as a fresh row.
